// File: rtl/multi_timer.sv
// multi_timer: NUM_CH programmable down-counter timers on the CPU bridge bus.
// Each channel has a prescaler, a sticky W1C pending flag and three modes.
// Build option: define MULTI_TIMER_PRESCALER_EN to enable the per-channel prescaler.
// Register map per channel (Addr[5:2]=channel, Addr[1:0]=register):
//   0 CTRL   [0] EN, [2:1] MODE, [3] IM, [4+PSC_W-1:4] PSC (prescaler builds only)
//   1 PRESET reload value, zero-extended on read
//   2 COUNT  live count, read-only
//   3 STATUS [0] PEND, write 1 to clear
module multi_timer #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int PSC_W  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [5:0]        Addr,
    input  logic              WE,
    input  logic [31:0]       WD,
    output logic [31:0]       RD,
    output logic [NUM_CH-1:0] IRQ_VEC,
    output logic              IRQ
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd2;
    localparam logic [1:0] MODE_STOP     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    logic [3:0] acc_ch;
    logic [1:0] acc_reg;

    assign acc_ch  = Addr[5:2];
    assign acc_reg = Addr[1:0];

    state_e           state_q  [NUM_CH];
    state_e           state_d  [NUM_CH];
    logic             en_q     [NUM_CH];
    logic             en_d     [NUM_CH];
    logic [1:0]       mode_q   [NUM_CH];
    logic [1:0]       mode_d   [NUM_CH];
    logic             im_q     [NUM_CH];
    logic             im_d     [NUM_CH];
    logic [CNT_W-1:0] preset_q [NUM_CH];
    logic [CNT_W-1:0] preset_d [NUM_CH];
    logic [CNT_W-1:0] count_q  [NUM_CH];
    logic [CNT_W-1:0] count_d  [NUM_CH];
    logic             pend_q   [NUM_CH];
    logic             pend_d   [NUM_CH];
    logic [NUM_CH-1:0] tick;

`ifdef MULTI_TIMER_PRESCALER_EN
    logic [PSC_W-1:0] psc_q [NUM_CH];
    logic [PSC_W-1:0] psc_d [NUM_CH];
    logic [PSC_W-1:0] pre_q [NUM_CH];
    logic [PSC_W-1:0] pre_d [NUM_CH];

    // A tick fires when the prescaler has counted up to the programmed PSC.
    always_comb begin
        tick = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tick[i] = (pre_q[i] == psc_q[i]);
        end
    end
`else
    localparam int unused_psc_w = PSC_W;

    // Without the prescaler every cycle is a tick.
    always_comb begin
        tick = '1;
    end
`endif

    // Only part of the write data is architected; the rest is intentionally dropped.
    logic unused_wd;
    assign unused_wd = ^WD;

    // Next-state for every channel: a bus write to the channel wins over its FSM.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            en_d[i]     = en_q[i];
            mode_d[i]   = mode_q[i];
            im_d[i]     = im_q[i];
            preset_d[i] = preset_q[i];
            count_d[i]  = count_q[i];
            pend_d[i]   = pend_q[i];
`ifdef MULTI_TIMER_PRESCALER_EN
            psc_d[i]    = psc_q[i];
            pre_d[i]    = pre_q[i];
`endif
            if (WE && (acc_ch == 4'(i))) begin
                // The write freezes state, COUNT and prescaler for this cycle.
                case (acc_reg)
                    REG_CTRL: begin
                        en_d[i]   = WD[0];
                        mode_d[i] = WD[2:1];
                        im_d[i]   = WD[3];
`ifdef MULTI_TIMER_PRESCALER_EN
                        psc_d[i]  = WD[4 +: PSC_W];
`endif
                    end
                    REG_PRESET: preset_d[i] = WD[CNT_W-1:0];
                    REG_STATUS: begin
                        if (WD[0]) begin
                            pend_d[i] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (en_q[i]) begin
                            state_d[i] = ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        count_d[i] = preset_q[i];
`ifdef MULTI_TIMER_PRESCALER_EN
                        pre_d[i]   = '0;
`endif
                        state_d[i] = ST_CNT;
                    end
                    ST_CNT: begin
                        if (!en_q[i] || (mode_q[i] == MODE_STOP)) begin
                            state_d[i] = ST_IDLE;
                        end else begin
`ifdef MULTI_TIMER_PRESCALER_EN
                            pre_d[i] = tick[i] ? '0 : pre_q[i] + PSC_W'(1);
`endif
                            if (tick[i]) begin
                                // PRESET=0 lands here on the first tick, so it acts like 1.
                                if (count_q[i] <= CNT_W'(1)) begin
                                    count_d[i] = '0;
                                    pend_d[i]  = 1'b1;
                                    state_d[i] = ST_INT;
                                    if (mode_q[i] == MODE_ONESHOT) begin
                                        en_d[i] = 1'b0;
                                    end
                                end else begin
                                    count_d[i] = count_q[i] - CNT_W'(1);
                                end
                            end
                        end
                    end
                    ST_INT: begin
                        // Periodic mode reloads straight away; others re-arm through IDLE.
                        state_d[i] = (mode_q[i] == MODE_PERIODIC) ? ST_LOAD : ST_IDLE;
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    // Register all channel state; synchronous reset clears everything.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (Reset) begin
                state_q[i]  <= ST_IDLE;
                en_q[i]     <= 1'b0;
                mode_q[i]   <= 2'd0;
                im_q[i]     <= 1'b0;
                preset_q[i] <= '0;
                count_q[i]  <= '0;
                pend_q[i]   <= 1'b0;
`ifdef MULTI_TIMER_PRESCALER_EN
                psc_q[i]    <= '0;
                pre_q[i]    <= '0;
`endif
            end else begin
                state_q[i]  <= state_d[i];
                en_q[i]     <= en_d[i];
                mode_q[i]   <= mode_d[i];
                im_q[i]     <= im_d[i];
                preset_q[i] <= preset_d[i];
                count_q[i]  <= count_d[i];
                pend_q[i]   <= pend_d[i];
`ifdef MULTI_TIMER_PRESCALER_EN
                psc_q[i]    <= psc_d[i];
                pre_q[i]    <= pre_d[i];
`endif
            end
        end
    end

    // Combinational read mux; channels beyond NUM_CH never match and read 0.
    always_comb begin
        RD = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc_ch == 4'(i)) begin
                case (acc_reg)
                    REG_CTRL: begin
                        RD = 32'({im_q[i], mode_q[i], en_q[i]});
`ifdef MULTI_TIMER_PRESCALER_EN
                        RD = RD | (32'(psc_q[i]) << 4);
`endif
                    end
                    REG_PRESET: RD = 32'(preset_q[i]);
                    REG_COUNT:  RD = 32'(count_q[i]);
                    REG_STATUS: RD = 32'(pend_q[i]);
                    default:    RD = '0;
                endcase
            end
        end
    end

    // Interrupts are the masked pending flags, plus their OR.
    always_comb begin
        IRQ_VEC = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            IRQ_VEC[i] = pend_q[i] & im_q[i];
        end
        IRQ = |IRQ_VEC;
    end

endmodule
